// File: rtl/packet_demux_pkg.sv
// packet_demux_pkg
// Shared framing definitions for the packet mux/demux pair. The header layout
// lives here so both ends of a link agree on template, mask and field positions.
//   - HDR_* constants  : default header template, magic mask and field shifts
//   - demux_state_t    : parser state encoding used by packet_demux
package packet_demux_pkg;

    // Both the payload count and the channel number are 4-bit header fields.
    localparam int HDR_FIELD_WIDTH = 4;

    // One extra bit so limits such as 16 channels fit without wrapping to 0.
    localparam int HDR_LIMIT_WIDTH = HDR_FIELD_WIDTH + 1;

    localparam logic [31:0] HDR_TEMPLATE      = 32'h2301_0000;
    localparam logic [31:0] HDR_MAGIC_MASK    = 32'hFFFF_0000;
    localparam int          HDR_COUNT_SHIFT   = 0;
    localparam int          HDR_CHANNEL_SHIFT = 8;
    localparam int          HDR_END_SHIFT     = 12;

    // DISCARD is kept as a reserved encoding; the parser treats it like HEADER.
    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } demux_state_t;

endpackage

// File: rtl/packet_demux_header_decode.sv
// packet_demux_header_decode
// Purely combinational header parser: splits a candidate header word into its
// fields and decides whether it is a usable header.
// Ports:
//   data    in   WORD_SIZE        candidate header word
//   valid   out  1                magic matches, 1 <= count <= SEGMENT_SIZE, channel < CHANNELS
//   count   out  HDR_FIELD_WIDTH  payload word count field
//   channel out  HDR_FIELD_WIDTH  destination channel field
//   eop     out  1                segment closes its packet
module packet_demux_header_decode
    import packet_demux_pkg::*;
#(
    parameter int                   CHANNELS             = 8,
    parameter int                   WORD_SIZE            = 32,
    parameter int                   SEGMENT_SIZE         = 4,
    parameter logic [WORD_SIZE-1:0] HEADER_TEMPLATE      = WORD_SIZE'(HDR_TEMPLATE),
    parameter logic [WORD_SIZE-1:0] HEADER_MAGIC_MASK    = WORD_SIZE'(HDR_MAGIC_MASK),
    parameter int                   HEADER_COUNT_SHIFT   = HDR_COUNT_SHIFT,
    parameter int                   HEADER_CHANNEL_SHIFT = HDR_CHANNEL_SHIFT,
    parameter int                   HEADER_END_SHIFT     = HDR_END_SHIFT
) (
    input  logic [WORD_SIZE-1:0]       data,
    output logic                       valid,
    output logic [HDR_FIELD_WIDTH-1:0] count,
    output logic [HDR_FIELD_WIDTH-1:0] channel,
    output logic                       eop
);

    localparam logic [HDR_LIMIT_WIDTH-1:0] COUNT_LIMIT   = HDR_LIMIT_WIDTH'(SEGMENT_SIZE);
    localparam logic [HDR_LIMIT_WIDTH-1:0] CHANNEL_LIMIT = HDR_LIMIT_WIDTH'(CHANNELS);

    logic magic_ok;

    assign magic_ok = (data & HEADER_MAGIC_MASK) == (HEADER_TEMPLATE & HEADER_MAGIC_MASK);
    assign count    = data[HEADER_COUNT_SHIFT +: HDR_FIELD_WIDTH];
    assign channel  = data[HEADER_CHANNEL_SHIFT +: HDR_FIELD_WIDTH];
    assign eop      = data[HEADER_END_SHIFT];

    // A zero count would leave the parser with nothing to route, so it is
    // rejected along with oversized segments and channels that do not exist.
    assign valid = magic_ok
                && (count != '0)
                && ({1'b0, count} <= COUNT_LIMIT)
                && ({1'b0, channel} < CHANNEL_LIMIT);

endmodule

// File: rtl/packet_demux.sv
// packet_demux
// Splits one header-framed word stream into per-channel word streams with
// end-of-packet marks. Each header announces channel, payload count and an end
// flag; the following payload words are steered to that channel with no added
// latency. Bad headers are skipped one word at a time until framing is regained.
// Ports:
//   clk        in   1              clock
//   rst        in   1              synchronous active-high reset
//   in_nempty  in   1              upstream FWFT fifo holds a word
//   in_data    in   WORD_SIZE      current upstream word
//   in_pop     out  1              consume in_data this cycle
//   out_full   in   CHANNELS       per-channel downstream full
//   out_shift  out  CHANNELS       one-hot write strobe
//   out_data   out  WORD_SIZE      payload word shared by all channels
//   out_end    out  1              out_data is the last word of a packet
//   synced     out  1              last accepted header was valid
//   err_count  out  COUNTER_WIDTH  bad headers seen, saturating
//   seg_count  out  COUNTER_WIDTH  valid segments routed, wrapping
module packet_demux
    import packet_demux_pkg::*;
#(
    parameter int                   CHANNELS             = 8,
    parameter int                   WORD_SIZE            = 32,
    parameter int                   SEGMENT_SIZE         = 4,
    parameter logic [WORD_SIZE-1:0] HEADER_TEMPLATE      = WORD_SIZE'(HDR_TEMPLATE),
    parameter logic [WORD_SIZE-1:0] HEADER_MAGIC_MASK    = WORD_SIZE'(HDR_MAGIC_MASK),
    parameter int                   HEADER_COUNT_SHIFT   = HDR_COUNT_SHIFT,
    parameter int                   HEADER_CHANNEL_SHIFT = HDR_CHANNEL_SHIFT,
    parameter int                   HEADER_END_SHIFT     = HDR_END_SHIFT,
    parameter int                   COUNTER_WIDTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_nempty,
    input  logic [WORD_SIZE-1:0]     in_data,
    output logic                     in_pop,
    input  logic [CHANNELS-1:0]      out_full,
    output logic [CHANNELS-1:0]      out_shift,
    output logic [WORD_SIZE-1:0]     out_data,
    output logic                     out_end,
    output logic                     synced,
    output logic [COUNTER_WIDTH-1:0] err_count,
    output logic [COUNTER_WIDTH-1:0] seg_count
);

    demux_state_t               state;
    demux_state_t               state_next;
    logic [HDR_FIELD_WIDTH-1:0] remaining;
    logic [HDR_FIELD_WIDTH-1:0] cur_channel;
    logic                       cur_end;
    logic [CHANNELS-1:0]        channel_mask;

    logic                       hdr_valid;
    logic [HDR_FIELD_WIDTH-1:0] hdr_count;
    logic [HDR_FIELD_WIDTH-1:0] hdr_channel;
    logic                       hdr_end;

    packet_demux_header_decode #(
        .CHANNELS             (CHANNELS),
        .WORD_SIZE            (WORD_SIZE),
        .SEGMENT_SIZE         (SEGMENT_SIZE),
        .HEADER_TEMPLATE      (HEADER_TEMPLATE),
        .HEADER_MAGIC_MASK    (HEADER_MAGIC_MASK),
        .HEADER_COUNT_SHIFT   (HEADER_COUNT_SHIFT),
        .HEADER_CHANNEL_SHIFT (HEADER_CHANNEL_SHIFT),
        .HEADER_END_SHIFT     (HEADER_END_SHIFT)
    ) u_header_decode (
        .data    (in_data),
        .valid   (hdr_valid),
        .count   (hdr_count),
        .channel (hdr_channel),
        .eop     (hdr_end)
    );

    // One-hot select of the latched channel; also used to pick its full flag so
    // no out-of-range bit select is ever needed when CHANNELS < 16.
    assign channel_mask = CHANNELS'(1) << cur_channel;

    // Next state and all stream-side outputs. Nothing is popped while reset is
    // held, so the upstream fifo never loses a word to a reset cycle.
    always_comb begin
        state_next = state;
        in_pop     = 1'b0;
        out_shift  = '0;
        out_data   = '0;
        out_end    = 1'b0;
        case (state)
            ST_PAYLOAD: begin
                // A full channel stalls the entire stream so ordering is kept.
                in_pop = in_nempty && !(|(out_full & channel_mask)) && !rst;
                if (in_pop) begin
                    out_shift = channel_mask;
                    out_data  = in_data;
                    out_end   = cur_end && (remaining == HDR_FIELD_WIDTH'(1));
                    if (remaining == HDR_FIELD_WIDTH'(1)) begin
                        state_next = ST_HEADER;
                    end
                end
            end
            default: begin
                in_pop = in_nempty && !rst;
                if (in_pop && hdr_valid) begin
                    state_next = ST_PAYLOAD;
                end
            end
        endcase
    end

    // State register plus segment bookkeeping and status counters. A rejected
    // header word is simply dropped, so the very next word is tried as a header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HEADER;
            remaining   <= '0;
            cur_channel <= '0;
            cur_end     <= 1'b0;
            synced      <= 1'b0;
            err_count   <= '0;
            seg_count   <= '0;
        end else begin
            state <= state_next;
            if (in_pop) begin
                if (state == ST_PAYLOAD) begin
                    remaining <= remaining - HDR_FIELD_WIDTH'(1);
                end else if (hdr_valid) begin
                    remaining   <= hdr_count;
                    cur_channel <= hdr_channel;
                    cur_end     <= hdr_end;
                    synced      <= 1'b1;
                    seg_count   <= seg_count + COUNTER_WIDTH'(1);
                end else begin
                    synced <= 1'b0;
                    if (err_count != '1) begin
                        err_count <= err_count + COUNTER_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_demux.sv
// tb_packet_demux
// Directed and randomised stimulus for packet_demux with hand-derived expected
// values. Inputs change 1ns after a rising edge; combinational outputs are
// sampled on the falling edge, registered status right after the rising edge.
module tb_packet_demux;

    logic        clk;
    logic        rst;
    logic        in_nempty;
    logic [31:0] in_data;
    logic        in_pop;
    logic [7:0]  out_full;
    logic [7:0]  out_shift;
    logic [31:0] out_data;
    logic        out_end;
    logic        synced;
    logic [15:0] err_count;
    logic [15:0] seg_count;

    int checks;
    int errors;

    packet_demux dut (
        .clk       (clk),
        .rst       (rst),
        .in_nempty (in_nempty),
        .in_data   (in_data),
        .in_pop    (in_pop),
        .out_full  (out_full),
        .out_shift (out_shift),
        .out_data  (out_data),
        .out_end   (out_end),
        .synced    (synced),
        .err_count (err_count),
        .seg_count (seg_count)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream of the bounded loops hangs.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_nempty = 1'b0;
        out_full  = '0;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_nempty = 1'b1;
        in_data   = 32'h2301_1204;
        out_full  = '0;
        advance();
        advance();
        @(negedge clk);
        checks++; if (in_pop !== 1'b0) begin errors++; $display("[TB] FAIL reset in_pop: got %b expected 0", in_pop); end
        checks++; if (out_shift !== 8'h00) begin errors++; $display("[TB] FAIL reset out_shift: got %h expected 00", out_shift); end
        checks++; if (out_end !== 1'b0) begin errors++; $display("[TB] FAIL reset out_end: got %b expected 0", out_end); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset out_data: got %h expected 0", out_data); end
        checks++; if (synced !== 1'b0) begin errors++; $display("[TB] FAIL reset synced: got %b expected 0", synced); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("[TB] FAIL reset err_count: got %h expected 0", err_count); end
        checks++; if (seg_count !== 16'h0) begin errors++; $display("[TB] FAIL reset seg_count: got %h expected 0", seg_count); end
        rst       = 1'b0;
        in_nempty = 1'b0;
        advance();
    endtask

    task automatic test_single_segment();
        in_nempty = 1'b1;
        in_data   = 32'h2301_1204;
        @(negedge clk);
        checks++; if (in_pop !== 1'b1) begin errors++; $display("[TB] FAIL single hdr in_pop: got %b expected 1", in_pop); end
        checks++; if (out_shift !== 8'h00) begin errors++; $display("[TB] FAIL single hdr out_shift: got %h expected 00", out_shift); end
        advance();
        checks++; if (synced !== 1'b1) begin errors++; $display("[TB] FAIL single synced: got %b expected 1", synced); end
        checks++; if (seg_count !== 16'd1) begin errors++; $display("[TB] FAIL single seg_count: got %0d expected 1", seg_count); end
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            checks++; if (in_pop !== 1'b1) begin errors++; $display("[TB] FAIL single word%0d in_pop: got %b expected 1", i, in_pop); end
            checks++; if (out_shift !== 8'h04) begin errors++; $display("[TB] FAIL single word%0d out_shift: got %h expected 04", i, out_shift); end
            checks++; if (out_data !== 32'hA000_0000 + 32'(i)) begin errors++; $display("[TB] FAIL single word%0d out_data: got %h expected %h", i, out_data, 32'hA000_0000 + 32'(i)); end
            checks++; if (out_end !== (i == 3)) begin errors++; $display("[TB] FAIL single word%0d out_end: got %b expected %b", i, out_end, (i == 3)); end
            advance();
        end
        in_nempty = 1'b0;
        @(negedge clk);
        checks++; if (in_pop !== 1'b0) begin errors++; $display("[TB] FAIL single idle in_pop: got %b expected 0", in_pop); end
        checks++; if (out_shift !== 8'h00) begin errors++; $display("[TB] FAIL single idle out_shift: got %h expected 00", out_shift); end
        advance();
    endtask

    task automatic test_two_segments();
        logic [31:0] words     [5] = '{32'h2301_0302, 32'hB000_0000, 32'hB000_0001, 32'h2301_1301, 32'hB000_0002};
        logic [7:0]  exp_shift [5] = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h08};
        logic        exp_end   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        in_nempty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = words[i];
            @(negedge clk);
            checks++; if (in_pop !== 1'b1) begin errors++; $display("[TB] FAIL two_seg step%0d in_pop: got %b expected 1", i, in_pop); end
            checks++; if (out_shift !== exp_shift[i]) begin errors++; $display("[TB] FAIL two_seg step%0d out_shift: got %h expected %h", i, out_shift, exp_shift[i]); end
            checks++; if (out_end !== exp_end[i]) begin errors++; $display("[TB] FAIL two_seg step%0d out_end: got %b expected %b", i, out_end, exp_end[i]); end
            advance();
        end
        in_nempty = 1'b0;
        checks++; if (seg_count !== 16'd3) begin errors++; $display("[TB] FAIL two_seg seg_count: got %0d expected 3", seg_count); end
    endtask

    task automatic test_bad_headers();
        logic [31:0] words      [5] = '{32'hDEAD_BEEF, 32'h2301_0000, 32'h2301_0901, 32'h2301_1101, 32'hC000_0000};
        logic [7:0]  exp_shift  [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        logic        exp_end    [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] exp_err    [5] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
        logic        exp_synced [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        in_nempty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = words[i];
            @(negedge clk);
            checks++; if (out_shift !== exp_shift[i]) begin errors++; $display("[TB] FAIL bad_hdr step%0d out_shift: got %h expected %h", i, out_shift, exp_shift[i]); end
            checks++; if (out_end !== exp_end[i]) begin errors++; $display("[TB] FAIL bad_hdr step%0d out_end: got %b expected %b", i, out_end, exp_end[i]); end
            advance();
            checks++; if (err_count !== exp_err[i]) begin errors++; $display("[TB] FAIL bad_hdr step%0d err_count: got %0d expected %0d", i, err_count, exp_err[i]); end
            checks++; if (synced !== exp_synced[i]) begin errors++; $display("[TB] FAIL bad_hdr step%0d synced: got %b expected %b", i, synced, exp_synced[i]); end
        end
        in_nempty = 1'b0;
        checks++; if (seg_count !== 16'd4) begin errors++; $display("[TB] FAIL bad_hdr seg_count: got %0d expected 4", seg_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] words     [4] = '{32'hD000_0000, 32'h0BAD_0BAD, 32'hD000_0001, 32'hD000_0002};
        logic        nempty    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0]  exp_shift [4] = '{8'h20, 8'h00, 8'h20, 8'h20};
        logic        exp_end   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        in_nempty = 1'b1;
        in_data   = 32'h2301_1503;
        advance();
        out_full = 8'h20;
        in_data  = 32'hD000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (in_pop !== 1'b0) begin errors++; $display("[TB] FAIL stall cycle%0d in_pop: got %b expected 0", i, in_pop); end
            checks++; if (out_shift !== 8'h00) begin errors++; $display("[TB] FAIL stall cycle%0d out_shift: got %h expected 00", i, out_shift); end
            advance();
        end
        // Every other channel full must not hold back channel 5.
        out_full = 8'hDF;
        for (int i = 0; i < 4; i++) begin
            in_nempty = nempty[i];
            in_data   = words[i];
            @(negedge clk);
            checks++; if (in_pop !== nempty[i]) begin errors++; $display("[TB] FAIL release step%0d in_pop: got %b expected %b", i, in_pop, nempty[i]); end
            checks++; if (out_shift !== exp_shift[i]) begin errors++; $display("[TB] FAIL release step%0d out_shift: got %h expected %h", i, out_shift, exp_shift[i]); end
            checks++; if (out_end !== exp_end[i]) begin errors++; $display("[TB] FAIL release step%0d out_end: got %b expected %b", i, out_end, exp_end[i]); end
            if (nempty[i]) begin
                checks++; if (out_data !== words[i]) begin errors++; $display("[TB] FAIL release step%0d out_data: got %h expected %h", i, out_data, words[i]); end
            end
            advance();
        end
        in_nempty = 1'b0;
        out_full  = '0;
        checks++; if (seg_count !== 16'd5) begin errors++; $display("[TB] FAIL release seg_count: got %0d expected 5", seg_count); end
    endtask

    task automatic test_reset_mid_segment();
        in_nempty = 1'b1;
        in_data   = 32'h2301_1404;
        advance();
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h0000_00E0 + 32'(i);
            @(negedge clk);
            checks++; if (out_shift !== 8'h10) begin errors++; $display("[TB] FAIL rst_mid word%0d out_shift: got %h expected 10", i, out_shift); end
            advance();
        end
        rst     = 1'b1;
        in_data = 32'h0000_00E2;
        @(negedge clk);
        checks++; if (in_pop !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid in_pop: got %b expected 0", in_pop); end
        checks++; if (out_shift !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid out_shift: got %h expected 00", out_shift); end
        checks++; if (out_end !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid out_end: got %b expected 0", out_end); end
        advance();
        rst = 1'b0;
        checks++; if (synced !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid synced: got %b expected 0", synced); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid err_count: got %0d expected 0", err_count); end
        checks++; if (seg_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid seg_count: got %0d expected 0", seg_count); end
        // Leftover payload words are now parsed as headers.
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h0000_00E2 + 32'(i);
            @(negedge clk);
            checks++; if (in_pop !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid left%0d in_pop: got %b expected 1", i, in_pop); end
            checks++; if (out_shift !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid left%0d out_shift: got %h expected 00", i, out_shift); end
            advance();
            checks++; if (err_count !== 16'(i + 1)) begin errors++; $display("[TB] FAIL rst_mid left%0d err_count: got %0d expected %0d", i, err_count, i + 1); end
        end
        in_nempty = 1'b0;
    endtask

    task automatic test_random_segments();
        logic [31:0] stim [$];
        logic [35:0] expq [$];
        logic [35:0] e;
        logic [7:0]  e_shift;
        int          ch, cnt, eop, cycles;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            ch  = $urandom_range(0, 7);
            cnt = $urandom_range(1, 4);
            eop = $urandom_range(0, 1);
            stim.push_back(32'h2301_0000 | (32'(eop) << 12) | (32'(ch) << 8) | 32'(cnt));
            for (int k = 0; k < cnt; k++) begin
                logic [31:0] d;
                d = $urandom;
                stim.push_back(d);
                expq.push_back({(eop == 1) && (k == cnt - 1), 3'(ch), d});
            end
        end
        cycles = 0;
        while (stim.size() != 0 && cycles < 4000) begin
            in_nempty = ($urandom_range(0, 3) != 0);
            in_data   = in_nempty ? stim[0] : $urandom;
            out_full  = 8'($urandom & $urandom & $urandom);
            @(negedge clk);
            checks++; if (in_pop && !in_nempty) begin errors++; $display("[TB] FAIL random pop_empty: got in_pop=1 expected 0"); end
            if (out_shift != 8'h00) begin
                checks++; if ($countones(out_shift) != 1) begin errors++; $display("[TB] FAIL random onehot: got %h expected one bit", out_shift); end
                checks++; if ((out_shift & out_full) != 8'h00) begin errors++; $display("[TB] FAIL random write_full: got shift %h full %h expected no overlap", out_shift, out_full); end
                if (expq.size() == 0) begin
                    checks++; errors++; $display("[TB] FAIL random extra_write: got shift %h expected none", out_shift);
                end else begin
                    e       = expq.pop_front();
                    e_shift = 8'h01 << e[34:32];
                    checks++; if (out_shift !== e_shift) begin errors++; $display("[TB] FAIL random channel: got %h expected %h", out_shift, e_shift); end
                    checks++; if (out_data !== e[31:0]) begin errors++; $display("[TB] FAIL random data: got %h expected %h", out_data, e[31:0]); end
                    checks++; if (out_end !== e[35]) begin errors++; $display("[TB] FAIL random end: got %b expected %b", out_end, e[35]); end
                end
            end
            if (in_pop && in_nempty) void'(stim.pop_front());
            advance();
            cycles++;
        end
        in_nempty = 1'b0;
        out_full  = '0;
        checks++; if (stim.size() != 0) begin errors++; $display("[TB] FAIL random timeout: got %0d words left expected 0", stim.size()); end
        checks++; if (expq.size() != 0) begin errors++; $display("[TB] FAIL random missing: got %0d writes left expected 0", expq.size()); end
        checks++; if (seg_count !== 16'd40) begin errors++; $display("[TB] FAIL random seg_count: got %0d expected 40", seg_count); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL random err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_err_saturation();
        do_reset();
        in_nempty = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        repeat (65534) advance();
        checks++; if (err_count !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat near: got %h expected FFFE", err_count); end
        repeat (3) advance();
        checks++; if (err_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat hold: got %h expected FFFF", err_count); end
        checks++; if (synced !== 1'b0) begin errors++; $display("[TB] FAIL sat synced: got %b expected 0", synced); end
        in_nempty = 1'b0;
    endtask

    // Scenario sequence; each task leaves the parser idle in HEADER.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_nempty = 1'b0;
        in_data   = '0;
        out_full  = '0;
        test_reset();
        test_single_segment();
        test_two_segments();
        test_bad_headers();
        test_backpressure();
        test_reset_mid_segment();
        test_random_segments();
        test_err_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
